rc4_sched_ctrl: RTL

Sequencing controller for the RC4 cipher core: it owns the 256×8 S-box RAM port and runs key load, S-box initialisation (S[i]=i), the key-scheduling algorithm (KSA) and the pseudo-random generation algorithm (PRGA). It emits one keystream byte per valid/ready handshake. The byte goes to the RC4 top, which XORs it with data. The block sits between the RC4 top-level FSM and an external single-port synchronous S-box RAM.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/rc4_key_buf.sv | 70 +++++++
 rtl/rc4_sched_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and sizes for the RC4 scheduling controller.
package rc4_pkg;
   localparam int KEY_MAX_DEF = 16;
   localparam int BYTE_W      = 8;
   localparam int SBOX_DEPTH  = 256;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA_RI,
      ST_KSA_RJ,
      ST_KSA_WI,
      ST_KSA_WJ,
      ST_PRG_RI,
      ST_PRG_RJ,
      ST_PRG_WI,
      ST_PRG_WJ,
      ST_PRG_RT,
      ST_PRG_CAP,
      ST_PRG_OUT
   } rc4_state_e;
endpackage

// File: rtl/rc4_key_buf.sv
// Key register file: sequential write pointer, captured key length and a
// wrapping read index k used by the key schedule.
module rc4_key_buf
   import rc4_pkg::*;
#(
   parameter int KEY_MAX = KEY_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic              wr_last,
   input  logic [BYTE_W-1:0] wr_data,
   output logic              wr_done,
   input  logic              k_inc,
   input  logic              k_clr,
   output logic [BYTE_W-1:0] key_byte
);
   localparam int IW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
   localparam int LW = IW + 1;

   logic [KEY_MAX-1:0][BYTE_W-1:0] mem_q, mem_d;
   logic [IW-1:0]                  ptr_q, ptr_d;
   logic [IW-1:0]                  k_q, k_d;
   logic [LW-1:0]                  len_q, len_d;

   // A full buffer closes the key even without an explicit last flag.
   assign wr_done  = wr_en && (wr_last || (ptr_q == IW'(KEY_MAX - 1)));
   assign key_byte = mem_q[k_q];

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      len_d = len_q;
      k_d   = k_q;
      if (clr) begin
         ptr_d = '0;
         len_d = '0;
         k_d   = '0;
      end else begin
         if (wr_en) begin
            mem_d[ptr_q] = wr_data;
            if (wr_done) begin
               len_d = LW'(ptr_q) + LW'(1);
               ptr_d = '0;
            end else begin
               ptr_d = ptr_q + IW'(1);
            end
         end
         if (k_clr)
            k_d = '0;
         else if (k_inc)
            k_d = (LW'(k_q) == len_q - LW'(1)) ? '0 : k_q + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         ptr_q <= '0;
         len_q <= '0;
         k_q   <= '0;
      end else begin
         mem_q <= mem_d;
         ptr_q <= ptr_d;
         len_q <= len_d;
         k_q   <= k_d;
      end
   end
endmodule

// File: rtl/rc4_sched_ctrl.sv
// RC4 sequencer: key load, S-box init, KSA and PRGA over a single-port
// synchronous S-box RAM; one keystream byte per valid/ready transfer.
module rc4_sched_ctrl
   import rc4_pkg::*;
#(
   parameter int KEY_MAX = KEY_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_rvalid,
   output logic              key_rready,
   input  logic [BYTE_W-1:0] key_in,
   input  logic              key_last,
   input  logic              flush,
   output logic              ks_wvalid,
   input  logic              ks_wready,
   output logic [BYTE_W-1:0] ks_out,
   output logic [BYTE_W-1:0] sbox_addr,
   output logic              sbox_we,
   output logic [BYTE_W-1:0] sbox_wdata,
   input  logic [BYTE_W-1:0] sbox_rdata,
   output logic              busy
);
   rc4_state_e        state_q, state_d;
   logic [BYTE_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
   logic [BYTE_W-1:0] ks_out_q, ks_out_d;
   logic              ks_wvalid_q, ks_wvalid_d;
   logic              key_wr, key_done, k_inc, k_clr;
   logic [BYTE_W-1:0] key_byte, i_nxt, j_ksa, j_prg;

   assign key_rready = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign ks_out     = ks_out_q;
   assign ks_wvalid  = ks_wvalid_q;
   assign key_wr     = (state_q == ST_IDLE) && key_rvalid && !flush;
   assign i_nxt      = i_q + 8'd1;
   assign j_ksa      = j_q + sbox_rdata + key_byte;
   assign j_prg      = j_q + sbox_rdata;

   rc4_key_buf #(.KEY_MAX(KEY_MAX)) u_key_buf (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (flush),
      .wr_en    (key_wr),
      .wr_last  (key_last),
      .wr_data  (key_in),
      .wr_done  (key_done),
      .k_inc    (k_inc),
      .k_clr    (k_clr),
      .key_byte (key_byte)
   );

   // RAM port is combinational: the RJ read address depends on the byte
   // returned in that same cycle, so it cannot be registered ahead of time.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      si_d        = si_q;
      sj_d        = sj_q;
      ks_out_d    = ks_out_q;
      ks_wvalid_d = ks_wvalid_q;
      k_inc       = 1'b0;
      k_clr       = 1'b0;
      sbox_addr   = '0;
      sbox_we     = 1'b0;
      sbox_wdata  = '0;
      unique case (state_q)
         ST_IDLE: if (key_done) begin
            state_d = ST_INIT;
            i_d     = '0;
         end
         ST_INIT: begin
            sbox_addr  = i_q;
            sbox_we    = 1'b1;
            sbox_wdata = i_q;
            i_d        = i_nxt;
            if (i_q == 8'(SBOX_DEPTH - 1)) begin
               state_d = ST_KSA_RI;
               j_d     = '0;
               k_clr   = 1'b1;
            end
         end
         ST_KSA_RI: begin
            sbox_addr = i_q;
            state_d   = ST_KSA_RJ;
         end
         ST_KSA_RJ: begin
            si_d      = sbox_rdata;
            j_d       = j_ksa;
            sbox_addr = j_ksa;
            state_d   = ST_KSA_WI;
         end
         ST_KSA_WI: begin
            sbox_addr  = i_q;
            sbox_we    = 1'b1;
            sbox_wdata = sbox_rdata;
            state_d    = ST_KSA_WJ;
         end
         ST_KSA_WJ: begin
            sbox_addr  = j_q;
            sbox_we    = 1'b1;
            sbox_wdata = si_q;
            i_d        = i_nxt;
            k_inc      = 1'b1;
            if (i_q == 8'(SBOX_DEPTH - 1)) begin
               state_d = ST_PRG_RI;
               j_d     = '0;
            end else begin
               state_d = ST_KSA_RI;
            end
         end
         ST_PRG_RI: begin
            i_d       = i_nxt;
            sbox_addr = i_nxt;
            state_d   = ST_PRG_RJ;
         end
         ST_PRG_RJ: begin
            si_d      = sbox_rdata;
            j_d       = j_prg;
            sbox_addr = j_prg;
            state_d   = ST_PRG_WI;
         end
         ST_PRG_WI: begin
            sj_d       = sbox_rdata;
            sbox_addr  = i_q;
            sbox_we    = 1'b1;
            sbox_wdata = sbox_rdata;
            state_d    = ST_PRG_WJ;
         end
         ST_PRG_WJ: begin
            sbox_addr  = j_q;
            sbox_we    = 1'b1;
            sbox_wdata = si_q;
            state_d    = ST_PRG_RT;
         end
         ST_PRG_RT: begin
            sbox_addr = si_q + sj_q;
            state_d   = ST_PRG_CAP;
         end
         ST_PRG_CAP: begin
            ks_out_d    = sbox_rdata;
            ks_wvalid_d = 1'b1;
            state_d     = ST_PRG_OUT;
         end
         ST_PRG_OUT: if (ks_wready) begin
            ks_wvalid_d = 1'b0;
            state_d     = ST_PRG_RI;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over any handshake in the same cycle.
      if (flush) begin
         state_d     = ST_IDLE;
         i_d         = '0;
         j_d         = '0;
         si_d        = '0;
         sj_d        = '0;
         ks_out_d    = '0;
         ks_wvalid_d = 1'b0;
         sbox_addr   = '0;
         sbox_we     = 1'b0;
         sbox_wdata  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         si_q        <= '0;
         sj_q        <= '0;
         ks_out_q    <= '0;
         ks_wvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         ks_out_q    <= ks_out_d;
         ks_wvalid_q <= ks_wvalid_d;
      end
   end
endmodule
